// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display path: segment patterns (bit0=a .. bit6=g)
// and the digit monitor state encoding.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        TRACK  = 2'd2,
        LOCKED = 2'd3
    } state_t;

    // Successor of a BCD digit, wrapping 9 -> 0.
    function automatic logic [3:0] bcd_next(input logic [3:0] d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/seg7_pattern_decoder.sv
// Combinational inverse of the segment decoder: pattern -> BCD digit plus
// flags telling a real digit apart from a blank display.
module seg7_pattern_decoder
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] digit,
    output logic       is_digit,
    output logic       is_blank
);

    always_comb begin
        digit    = 4'd0;
        is_digit = 1'b1;
        is_blank = 1'b0;
        case (pattern)
            SEG_0:     digit = 4'd0;
            SEG_1:     digit = 4'd1;
            SEG_2:     digit = 4'd2;
            SEG_3:     digit = 4'd3;
            SEG_4:     digit = 4'd4;
            SEG_5:     digit = 4'd5;
            SEG_6:     digit = 4'd6;
            SEG_7:     digit = 4'd7;
            SEG_8:     digit = 4'd8;
            SEG_9:     digit = 4'd9;
            SEG_BLANK: begin
                is_digit = 1'b0;
                is_blank = 1'b1;
            end
            default:   is_digit = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_digit_monitor.sv
// Receive-side checker: synchronizes and debounces a 7-segment pattern, decodes it and
// verifies the digit steps 0..9 once per MAX_COUNT clocks, reporting lock and errors.
module seg7_digit_monitor
    import seg7_pkg::*;
#(
    parameter int MAX_COUNT     = 10_000_000,
    parameter int TOLERANCE     = 1_000,
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  seg_in,
    output logic [3:0]  digit,
    output logic        digit_valid,
    output logic        locked,
    output logic        err_pulse,
    output logic [7:0]  err_count,
    output logic [23:0] period,
    output state_t      dbg_state
);

    localparam logic [24:0] WIN_LO    = 25'(MAX_COUNT - TOLERANCE);
    localparam logic [24:0] WIN_HI    = 25'(MAX_COUNT + TOLERANCE);
    localparam logic [3:0]  STABLE    = 4'(STABLE_CYCLES);
    localparam logic [23:0] TIMER_MAX = '1;

    logic [6:0]  sync1_q, sync2_q, samp_q, last_pat_q;
    logic [3:0]  run_q;
    logic [23:0] timer_q;
    state_t      state_q, state_d;
    logic [3:0]  dec_digit;
    logic        dec_is_digit, dec_is_blank;
    logic        stable, cand_new, ev_digit, ev_bad;
    logic        correct, in_window, timeout, step_ok, err;
    logic [24:0] elapsed;

    seg7_pattern_decoder u_decoder (
        .pattern  (samp_q),
        .digit    (dec_digit),
        .is_digit (dec_is_digit),
        .is_blank (dec_is_blank)
    );

    // The run counter saturates at STABLE, so a held pattern yields exactly one candidate event.
    assign stable    = (run_q == STABLE);
    assign cand_new  = stable && (samp_q != last_pat_q);
    assign ev_digit  = cand_new && dec_is_digit;
    assign ev_bad    = cand_new && !dec_is_digit && !dec_is_blank;
    assign elapsed   = {1'b0, timer_q} + 25'd1;
    assign in_window = (elapsed >= WIN_LO) && (elapsed <= WIN_HI);
    assign correct   = (dec_digit == bcd_next(digit));
    assign step_ok   = correct && in_window;
    assign timeout   = (state_q != IDLE) && ({1'b0, timer_q} > WIN_HI);

    always_comb begin
        state_d = state_q;
        err     = 1'b0;
        if (ev_bad) begin
            err     = 1'b1;
            state_d = SYNC;
        end else if (ev_digit) begin
            case (state_q)
                IDLE: state_d = SYNC;
                SYNC: begin
                    if (step_ok) state_d = TRACK;
                    else         err     = 1'b1;
                end
                TRACK, LOCKED: begin
                    state_d = step_ok ? LOCKED : SYNC;
                    err     = !step_ok;
                end
                default: state_d = IDLE;
            endcase
        end else if (timeout) begin
            // Leaving for IDLE makes the timeout a single-shot error.
            err     = 1'b1;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            samp_q      <= '0;
            run_q       <= '0;
            last_pat_q  <= '0;
            timer_q     <= '0;
            state_q     <= IDLE;
            digit       <= '0;
            digit_valid <= 1'b0;
            err_pulse   <= 1'b0;
            err_count   <= '0;
            period      <= '0;
        end else begin
            sync1_q <= seg_in;
            sync2_q <= sync1_q;
            samp_q  <= sync2_q;
            if (sync2_q != samp_q)  run_q <= 4'd1;
            else if (run_q < STABLE) run_q <= run_q + 4'd1;
            if (stable) last_pat_q <= samp_q;

            if (ev_digit || state_q == IDLE) timer_q <= '0;
            else if (timer_q != TIMER_MAX)  timer_q <= timer_q + 24'd1;

            state_q     <= state_d;
            digit_valid <= ev_digit;
            err_pulse   <= err;
            if (err && err_count != 8'hFF) err_count <= err_count + 8'd1;
            if (ev_digit) begin
                digit  <= dec_digit;
                period <= (timer_q == TIMER_MAX) ? TIMER_MAX : elapsed[23:0];
            end
        end
    end

    assign locked    = (state_q == LOCKED);
    assign dbg_state = state_q;

endmodule

// File: doc/seg7_digit_monitor.md
# seg7_digit_monitor

Receive-side checker for the seconds-counter display path: it reads a 7-segment pattern driven by another board or by our own `uo_out[6:0]` loopback, decodes it back to a BCD digit, and verifies that the digit advances 0→9→0 once per `MAX_COUNT` clocks. It is the reader for the counter + segment-decoder writer. Outputs feed the bidirectional GPIO and debug LEDs for bring-up and board-to-board link checks.

## Interface
- `MAX_COUNT`, 10_000_000: expected clocks between digit changes.
- `TOLERANCE`, 1_000: allowed ± deviation in clocks on each measured period.
- `STABLE_CYCLES`, 4: consecutive identical synchronized samples needed to accept a pattern; range 2..15.
- `clk`  in  1  system clock (10 MHz on board).
- `reset`  in  1  synchronous, active-high reset.
- `seg_in`  in  7  segment pattern, bit0=a … bit6=g, active high; asynchronous to `clk`.
- `digit`  out  4  last accepted digit; reset 0.
- `digit_valid`  out  1  one-cycle pulse per accepted digit change; reset 0.
- `locked`  out  1  high while in LOCKED; reset 0.
- `err_pulse`  out  1  one-cycle pulse per error; reset 0.
- `err_count`  out  8  saturating error count, stops at 255; reset 0.
- `period`  out  24  clocks between the last two accepted digits; reset 0.

## Operation
- `seg_in` passes through a 2-flop synchronizer (reset to 0).
- Stability filter: a run counter increments while the synchronized sample equals the previous one, and reloads to 1 on any change. When the run reaches `STABLE_CYCLES`, the sample becomes the candidate. A candidate differing from the last accepted pattern is an event, exactly once per pattern.
- Decode table (hex, g..a): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- Blank (00) is recorded as the last pattern but produces no event and no error.
- Any other pattern produces an error (`err_pulse`, `err_count`+1) and forces state SYNC.
- Period timer: clears to 0 on each valid event and otherwise increments, saturating at 2^24−1. On an event, `period` captures timer+1.
- In-window means MAX_COUNT−TOLERANCE ≤ timer+1 ≤ MAX_COUNT+TOLERANCE.
- Correct means digit == (previous digit + 1) mod 10, so 9→0 is correct.
- States:
  - IDLE: timer held at 0. Valid event → SYNC.
  - SYNC: reference digit set. Valid event that is correct and in-window → TRACK. Any other valid event → error, stay SYNC, new reference.
  - TRACK: correct and in-window → LOCKED. Otherwise → error, SYNC.
  - LOCKED: correct and in-window → stay. Otherwise → error, SYNC.
- Timeout: in SYNC, TRACK or LOCKED, when the timer exceeds MAX_COUNT+TOLERANCE with no event → error, IDLE. Fires once, not every cycle.
- Every valid decoded event updates `digit` and pulses `digit_valid`, including events that are errors.

## Timing
- A `seg_in` change held constant produces `digit_valid` exactly 2+`STABLE_CYCLES` clocks after the first edge that samples the new value.
- The latency is constant, so `period` equals the source's change-to-change spacing exactly.
- `locked`, `err_pulse`, `err_count` and `period` update on the same edge as `digit_valid`.
- Event and timeout on the same cycle: the event is judged and the timeout is ignored.
- Glitches shorter than `STABLE_CYCLES` are rejected silently.
- `reset` asserted mid-operation clears the synchronizer, filter, timer, state (IDLE) and all outputs on the next edge.
- At most one `err_pulse` per cycle.
- When `err_count` is 255, further errors still pulse `err_pulse`.

## Structure
- Shared package `seg7_pkg`:
  - the ten pattern constants and `SEG_BLANK`, also used by the existing segment decoder;
  - the state enum IDLE/SYNC/TRACK/LOCKED.
- Sub-module `seg7_pattern_decoder`: combinational, 7-bit pattern in → 4-bit digit plus `is_digit` and `is_blank` flags. Everything else stays in the top.

## Test plan
All scenarios use parameters MAX_COUNT=100, TOLERANCE=2, STABLE_CYCLES=4.
- Reset, then drive 3F,06,5B,4F at 100-clock spacing:
  - `digit_valid` 6 clocks after each change;
  - `digit` 0,1,2,3;
  - `period`=100 from the second event;
  - `locked` rises at the third event;
  - `err_count`=0.
- While locked, drive 6F then 3F 100 clocks apart (9→0 wrap): stays locked, no error.
- While locked, skip 3→5:
  - `err_pulse` once, `err_count`=1;
  - `locked` falls and state is SYNC;
  - next two correct 100-clock steps relock.
- Locked, then hold the pattern 103 clocks: the timeout pulses `err_pulse` once, `locked`=0, state IDLE; a spacing of 102 instead keeps lock.
- 3-clock glitch to 7F mid-digit gives no event; pattern 01 held 4+ clocks gives an error and SYNC; 00 held gives no error.
- Assert `reset` while locked with `err_count`=5: all outputs 0 next cycle; 256 bad patterns saturate `err_count` at 255.
